timer_count_core: RTL and testbench

- Counter stage directly downstream of the prescaler (`select_clock`) in the 8-bit timer.
- Takes the selected prescaled clock level `Clock_counter` and detects its rising edges synchronously in the PCLK domain.
- Advances an 8-bit up/down counter on each detected edge, supports a synchronous load from the data register, and raises sticky overflow/underflow status flags for the register/interrupt block.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_count_core_if.sv | 30 +++
 rtl/edge_detect_rise.sv | 30 +++
 rtl/timer_count_core.sv | 82 ++++++++
 tb/tb_timer_count_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer counter stage.
// Imported by the interface, the edge detector and timer_count_core.
package timer_pkg;

    localparam int CNT_W = 8;

    // Meaning of the Up_down input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Reset values of the counter and of the edge-detector delay register.
    localparam int   CNT_RST  = 0;
    localparam logic EDGE_RST = 1'b1;

    // What the counter does on the current PCLK edge.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } cnt_op_e;

endpackage

// File: rtl/timer_count_core_if.sv
// Register/interrupt-block side signals of the timer counter stage.
// The core uses the slave modport; whoever drives it uses master.
interface timer_count_core_if
    import timer_pkg::*;
#(
    parameter int WIDTH = CNT_W
);
    logic             Clock_counter;
    logic             En;
    logic             Up_down;
    logic             Load;
    logic [WIDTH-1:0] TDR;
    logic             Clr_ovf;
    logic             Clr_udf;
    logic [WIDTH-1:0] TCNT;
    logic             Tick;
    logic             S_ovf;
    logic             S_udf;

    modport master (
        output Clock_counter, En, Up_down, Load, TDR, Clr_ovf, Clr_udf,
        input  TCNT, Tick, S_ovf, S_udf
    );

    modport slave (
        input  Clock_counter, En, Up_down, Load, TDR, Clr_ovf, Clr_udf,
        output TCNT, Tick, S_ovf, S_udf
    );

endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a slow level sampled in the PCLK domain.
// Reusable for any external-clock style input; pulse is combinational.
module edge_detect_rise
    import timer_pkg::*;
#(
    parameter logic RST_VAL = EDGE_RST
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic level,
    output logic pulse
);

    logic level_d;

    // Resetting to 1 keeps a level that is already high at reset
    // release from looking like a fresh rising edge.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            level_d <= RST_VAL;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/timer_count_core.sv
// Counter stage behind the prescaler: counts rising edges of the selected
// clock level up or down, supports a synchronous load and sticky wrap flags.
module timer_count_core
    import timer_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic                PCLK,
    input  logic                PRESET,
    timer_count_core_if.slave   bus
);

    logic             tick;
    cnt_op_e          op;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_q;
    logic             udf_q;
    logic             ovf_set;
    logic             udf_set;

    // The detector tracks Clock_counter every cycle, independent of En and
    // Load, so re-enabling never produces a false edge.
    edge_detect_rise #(
        .RST_VAL (EDGE_RST)
    ) u_edge (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .level  (bus.Clock_counter),
        .pulse  (tick)
    );

    // Load wins over a coincident edge; that edge is dropped, not deferred.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        op = OP_HOLD;
        if (bus.Load) begin
            op = OP_LOAD;
        end else if (bus.En && tick) begin
            op = (bus.Up_down == DIR_UP) ? OP_INC : OP_DEC;
        end
    end

    // Wrap detection looks at the pre-update value.
    always_comb begin
        cnt_nxt = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case (op)
            OP_LOAD: cnt_nxt = bus.TDR;
            OP_INC: begin
                cnt_nxt = cnt_q + WIDTH'(1);
                ovf_set = (cnt_q == '1);
            end
            OP_DEC: begin
                cnt_nxt = cnt_q - WIDTH'(1);
                udf_set = (cnt_q == '0);
            end
            default: cnt_nxt = cnt_q;
        endcase
    end

    // Flags are sticky; a set in the same cycle as a clear wins.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= WIDTH'(CNT_RST);
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            ovf_q <= ovf_set | (ovf_q & ~bus.Clr_ovf);
            udf_q <= udf_set | (udf_q & ~bus.Clr_udf);
        end
    end

    assign bus.TCNT  = cnt_q;
    assign bus.Tick  = tick;
    assign bus.S_ovf = ovf_q;
    assign bus.S_udf = udf_q;

endmodule

// File: tb/tb_timer_count_core.sv
// Directed bench for timer_count_core: expected register state is queued
// when each step is driven and compared once the PCLK edge has happened.
module tb_timer_count_core;
    import timer_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] tcnt;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic PCLK;
    logic PRESET;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    timer_count_core_if #(.WIDTH(8)) bus ();

    timer_count_core #(.WIDTH(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] t, input logic o, input logic u);
        exp_t e;
        e.tag  = tag;
        e.tcnt = t;
        e.ovf  = o;
        e.udf  = u;
        sb.push_back(e);
    endtask

    // One PCLK edge, then compare the oldest queued expectation.
    task automatic step();
        exp_t e;
        @(posedge PCLK);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "/TCNT"},  bus.TCNT,  e.tcnt);
            check({e.tag, "/S_ovf"}, bus.S_ovf, e.ovf);
            check({e.tag, "/S_udf"}, bus.S_udf, e.udf);
        end
    endtask

    // One prescaled rising edge: level high for 2 PCLK then low for 2 PCLK.
    // ld/clr_o are applied only during the cycle the edge is detected.
    task automatic rise_edge(input string tag, input logic [7:0] t, input logic o,
                             input logic u, input logic exp_tick,
                             input logic ld = 1'b0, input logic clr_o = 1'b0);
        bus.Clock_counter = 1'b1;
        bus.Load          = ld;
        bus.Clr_ovf       = clr_o;
        #1;
        check({tag, "/tick_hi"}, bus.Tick, exp_tick);
        push(tag, t, o, u);
        step();
        bus.Load    = 1'b0;
        bus.Clr_ovf = 1'b0;
        check({tag, "/tick_lo"}, bus.Tick, 1'b0);
        push({tag, "_h1"}, t, o, u);
        step();
        bus.Clock_counter = 1'b0;
        push({tag, "_l0"}, t, o, u);
        step();
        push({tag, "_l1"}, t, o, u);
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset with the prescaled clock already high.
        PRESET            = 1'b1;
        bus.Clock_counter = 1'b1;
        bus.En            = 1'b0;
        bus.Up_down       = DIR_UP;
        bus.Load          = 1'b0;
        bus.TDR           = 8'h00;
        bus.Clr_ovf       = 1'b0;
        bus.Clr_udf       = 1'b0;
        push("rst0", 8'h00, 1'b0, 1'b0);
        step();
        push("rst1", 8'h00, 1'b0, 1'b0);
        step();
        PRESET = 1'b0;
        #1;
        check("rel/tick", bus.Tick, 1'b0);
        push("rel", 8'h00, 1'b0, 1'b0);
        step();
        check("rel/tick2", bus.Tick, 1'b0);
        bus.Clock_counter = 1'b0;
        push("rel_lo", 8'h00, 1'b0, 1'b0);
        step();

        // Load FD, count up across the overflow wrap.
        bus.TDR  = 8'hFD;
        bus.Load = 1'b1;
        push("ld_fd", 8'hFD, 1'b0, 1'b0);
        step();
        bus.Load    = 1'b0;
        bus.En      = 1'b1;
        bus.Up_down = DIR_UP;
        rise_edge("up_fe", 8'hFE, 1'b0, 1'b0, 1'b1);
        rise_edge("up_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
        rise_edge("up_00", 8'h00, 1'b1, 1'b0, 1'b1);
        rise_edge("up_01", 8'h01, 1'b1, 1'b0, 1'b1);

        // Load 01, count down across the underflow wrap, then clear S_udf.
        bus.TDR     = 8'h01;
        bus.Load    = 1'b1;
        bus.Up_down = DIR_DOWN;
        push("ld_01", 8'h01, 1'b1, 1'b0);
        step();
        bus.Load = 1'b0;
        rise_edge("dn_00", 8'h00, 1'b1, 1'b0, 1'b1);
        rise_edge("dn_ff", 8'hFF, 1'b1, 1'b1, 1'b1);
        bus.Clr_udf = 1'b1;
        push("clr_udf", 8'hFF, 1'b1, 1'b0);
        step();
        bus.Clr_udf = 1'b0;

        // Clear S_ovf alone, then wrap with Clr_ovf coincident: set wins.
        bus.Clr_ovf = 1'b1;
        push("clr_ovf", 8'hFF, 1'b0, 1'b0);
        step();
        bus.Clr_ovf = 1'b0;
        bus.Up_down = DIR_UP;
        rise_edge("set_wins", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Load coincident with a tick: the tick is discarded.
        bus.TDR = 8'h55;
        rise_edge("ld_vs_tick", 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Disabled: ticks still pulse, count frozen.
        bus.En = 1'b0;
        rise_edge("dis0", 8'h55, 1'b1, 1'b0, 1'b1);
        rise_edge("dis1", 8'h55, 1'b1, 1'b0, 1'b1);
        rise_edge("dis2", 8'h55, 1'b1, 1'b0, 1'b1);

        // Re-enable while the level is already high: no count.
        bus.Clock_counter = 1'b1;
        push("pre_en", 8'h55, 1'b1, 1'b0);
        step();
        bus.En = 1'b1;
        #1;
        check("reen/tick", bus.Tick, 1'b0);
        push("reen_hi", 8'h55, 1'b1, 1'b0);
        step();
        bus.Clock_counter = 1'b0;
        push("reen_lo", 8'h55, 1'b1, 1'b0);
        step();
        push("reen_lo1", 8'h55, 1'b1, 1'b0);
        step();
        rise_edge("reen_cnt", 8'h56, 1'b1, 1'b0, 1'b1);

        // PRESET mid-count overrides a coincident Load and tick.
        bus.TDR  = 8'h80;
        bus.Load = 1'b1;
        push("ld_80", 8'h80, 1'b1, 1'b0);
        step();
        bus.Load          = 1'b0;
        bus.TDR           = 8'h33;
        bus.Clock_counter = 1'b1;
        bus.Load          = 1'b1;
        PRESET            = 1'b1;
        push("preset", 8'h00, 1'b0, 1'b0);
        step();
        PRESET   = 1'b0;
        bus.Load = 1'b0;
        check("preset/tick", bus.Tick, 1'b0);
        push("post_rst", 8'h00, 1'b0, 1'b0);
        step();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
